// File: rtl/stream_resize_pkg.sv
// Shared definitions for the stream_upsize / stream_downsize width converters.
package stream_resize_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } resize_state_t;

  // Bits needed to hold a keep count in the range 0..ratio.
  function automatic int unsigned keep_width(input int unsigned ratio);
    return $clog2(ratio) + 1;
  endfunction

endpackage

// File: rtl/stream_downsize.sv
// Splits wide input beats of T_DATA_RATIO words into a narrow word stream, word 0 first.
// Define STREAM_DOWNSIZE_B2B_EN to load the next beat on the same edge the last word leaves.
module stream_downsize
  import stream_resize_pkg::*;
#(
  parameter int unsigned T_DATA_WIDTH = 32,
  parameter int unsigned T_DATA_RATIO = 4,
  parameter int unsigned T_KEEP_WIDTH = keep_width(T_DATA_RATIO)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [T_DATA_WIDTH-1:0] s_data_i [T_DATA_RATIO],
  input  logic [T_KEEP_WIDTH-1:0] s_keep_i,
  input  logic                    s_last_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o,
  output logic                    m_last_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i
);

  localparam int unsigned IDX_W = $clog2(T_DATA_RATIO);
  localparam logic [T_KEEP_WIDTH-1:0] RATIO_K = T_KEEP_WIDTH'(T_DATA_RATIO);
  localparam logic [T_KEEP_WIDTH-1:0] ONE_K = T_KEEP_WIDTH'(1);
  localparam logic [IDX_W-1:0] ONE_I = IDX_W'(1);

  resize_state_t           state;
  logic [T_DATA_WIDTH-1:0] buffer [T_DATA_RATIO];
  logic [IDX_W-1:0]        index;
  logic [IDX_W-1:0]        last_idx;
  logic                    last_flag;

  logic [T_KEEP_WIDTH-1:0] keep_clamped;
  logic                    keep_zero;
  logic                    at_end;
  logic                    s_xfer;
  logic                    m_xfer;

  always_comb begin
    keep_clamped = (s_keep_i > RATIO_K) ? RATIO_K : s_keep_i;
    keep_zero    = (keep_clamped == '0);
  end

  // last_idx holds k-1 so the end-of-beat test is a plain index compare.
  assign at_end = (index == last_idx);

`ifdef STREAM_DOWNSIZE_B2B_EN
  assign s_ready_o = !rst && ((state == IDLE) || (m_ready_i && at_end));
`else
  assign s_ready_o = !rst && (state == IDLE);
`endif

  assign m_valid_o = !rst && (state == SEND);
  assign m_data_o  = m_valid_o ? buffer[index] : '0;
  assign m_last_o  = m_valid_o && last_flag && at_end;

  assign s_xfer = s_valid_i && s_ready_o;
  assign m_xfer = m_valid_o && m_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      index     <= '0;
      last_idx  <= '0;
      last_flag <= 1'b0;
      for (int i = 0; i < T_DATA_RATIO; i++) begin
        buffer[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          // An empty beat is consumed here and its last flag dropped.
          if (s_xfer && !keep_zero) begin
            buffer    <= s_data_i;
            last_idx  <= IDX_W'(keep_clamped - ONE_K);
            last_flag <= s_last_i;
            index     <= '0;
            state     <= SEND;
          end
        end
        SEND: begin
          if (m_xfer) begin
            if (at_end) begin
              index <= '0;
              state <= IDLE;
              // Only reachable with back-to-back loading, where s_ready opens on the final word.
              if (s_xfer && !keep_zero) begin
                buffer    <= s_data_i;
                last_idx  <= IDX_W'(keep_clamped - ONE_K);
                last_flag <= s_last_i;
                state     <= SEND;
              end
            end else begin
              index <= index + ONE_I;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_downsize.sv
// Directed bench for stream_downsize: scoreboard of expected words plus timing checks.
module tb_stream_downsize;

  localparam int W  = 32;
  localparam int R  = 4;
  localparam int KW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  s_data [R];
  logic [KW-1:0] s_keep;
  logic          s_last;
  logic          s_valid;
  logic          s_ready;
  logic [W-1:0]  m_data;
  logic          m_last;
  logic          m_valid;
  logic          m_ready;

  always #5 clk = ~clk;

  stream_downsize #(
    .T_DATA_WIDTH(W),
    .T_DATA_RATIO(R),
    .T_KEEP_WIDTH(KW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_data_i (s_data),
    .s_keep_i (s_keep),
    .s_last_i (s_last),
    .s_valid_i(s_valid),
    .s_ready_o(s_ready),
    .m_data_o (m_data),
    .m_last_o (m_last),
    .m_valid_o(m_valid),
    .m_ready_i(m_ready)
  );

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic [W:0]  exp_q [$];
  int          xfer_cyc [$];

  logic        stall_seen = 1'b0;
  logic [W-1:0] stall_data = '0;
  logic        stall_last = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: a transfer happens at the next posedge iff valid && ready here.
  always @(negedge clk) begin
    logic [W:0] e;
    if (rst) begin
      stall_seen <= 1'b0;
    end else begin
      if (stall_seen) begin
        check("hold_valid", 64'(m_valid), 64'd1);
        check("hold_data", 64'(m_data), 64'(stall_data));
        check("hold_last", 64'(m_last), 64'(stall_last));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_word", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          check("word_data", 64'(m_data), 64'(e[W-1:0]));
          check("word_last", 64'(m_last), 64'(e[W]));
          xfer_cyc.push_back(cyc);
        end
      end
      stall_seen <= m_valid && !m_ready;
      stall_data <= m_data;
      stall_last <= m_last;
    end
  end

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send_beat(input logic [W-1:0] d0, input logic [W-1:0] d1,
                           input logic [W-1:0] d2, input logic [W-1:0] d3,
                           input int keep, input logic last);
    logic [W-1:0] d [R];
    int kc;
    bit done;
    done = 1'b0;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    for (int i = 0; i < R; i++) s_data[i] = d[i];
    s_keep  = keep[KW-1:0];
    s_last  = last;
    s_valid = 1'b1;
    kc = (keep > R) ? R : keep;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge clk);
      if (s_ready) begin
        for (int i = 0; i < kc; i++) exp_q.push_back({(last && (i == kc - 1)), d[i]});
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    check("accept", 64'(done), 64'd1);
  endtask

  task automatic drain(input string tag);
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !m_valid) break;
    end
    check(tag, 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int span;
    rst     = 1'b1;
    s_valid = 1'b0;
    s_keep  = '0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < R; i++) s_data[i] = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_valid", 64'(m_valid), 64'd0);
    check("reset_sready", 64'(s_ready), 64'd0);
    check("reset_data", 64'(m_data), 64'd0);
    check("reset_last", 64'(m_last), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("idle_sready", 64'(s_ready), 64'd1);
    check("idle_valid", 64'(m_valid), 64'd0);
    @(posedge clk);
    #1;

    // Full beat; word 0 must appear right after the accepting edge.
    send_beat(32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003, 4, 1'b1);
    @(negedge clk);
    check("lat_valid", 64'(m_valid), 64'd1);
    check("lat_data", 64'(m_data), 64'hA000_0000);
    check("lat_last", 64'(m_last), 64'd0);
    drain("drain_full");

    // Partial beat, then over-range keep clamped to the ratio.
    send_beat(32'hB000_0000, 32'hB000_0001, 32'hDEAD_0002, 32'hDEAD_0003, 2, 1'b0);
    send_beat(32'hC000_0000, 32'hC000_0001, 32'hC000_0002, 32'hC000_0003, 7, 1'b1);
    drain("drain_partial");

    // Empty beat with last set is swallowed.
    send_beat(32'hEEEE_0000, 32'hEEEE_0001, 32'hEEEE_0002, 32'hEEEE_0003, 0, 1'b1);
    @(negedge clk);
    check("zero_valid", 64'(m_valid), 64'd0);
    check("zero_sready", 64'(s_ready), 64'd1);
    @(posedge clk);
    #1;
    send_beat(32'hD000_0000, 32'hD000_0001, 32'hD000_0002, 32'hD000_0003, 4, 1'b1);
    drain("drain_after_zero");

    // Backpressure while word 1 is presented.
    send_beat(32'hE000_0000, 32'hE000_0001, 32'hE000_0002, 32'hE000_0003, 4, 1'b1);
    @(posedge clk);
    #1 m_ready = 1'b0;
    @(negedge clk);
    check("stall1_data", 64'(m_data), 64'hE000_0001);
    check("stall1_sready", 64'(s_ready), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("stall2_data", 64'(m_data), 64'hE000_0001);
    check("stall2_sready", 64'(s_ready), 64'd0);
    @(posedge clk);
    #1 m_ready = 1'b1;
    @(negedge clk);
    check("stall3_data", 64'(m_data), 64'hE000_0001);
    check("stall3_sready", 64'(s_ready), 64'd0);
    drain("drain_stall");

    // Two beats offered back to back.
    xfer_cyc.delete();
    send_beat(32'hF000_0000, 32'hF000_0001, 32'hF000_0002, 32'hF000_0003, 4, 1'b0);
    send_beat(32'h9000_0000, 32'h9000_0001, 32'h9000_0002, 32'h9000_0003, 4, 1'b1);
    drain("drain_b2b");
    check("b2b_count", 64'(xfer_cyc.size()), 64'd8);
    span = (xfer_cyc.size() == 8) ? (xfer_cyc[7] - xfer_cyc[0]) : -1;
`ifdef STREAM_DOWNSIZE_B2B_EN
    check("b2b_span", 64'(span), 64'd7);
`else
    check("b2b_span", 64'(span), 64'd8);
`endif

    // Reset while word 1 is pending discards the rest of the beat.
    send_beat(32'h7000_0000, 32'h7000_0001, 32'h7000_0002, 32'h7000_0003, 4, 1'b1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_valid", 64'(m_valid), 64'd0);
    check("rst_sready", 64'(s_ready), 64'd0);
    check("rst_data", 64'(m_data), 64'd0);
    check("rst_last", 64'(m_last), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("post_rst_valid", 64'(m_valid), 64'd0);
    check("post_rst_sready", 64'(s_ready), 64'd1);
    repeat (4) begin
      @(negedge clk);
      check("post_rst_quiet", 64'(m_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    send_beat(32'h6000_0000, 32'h6000_0001, 32'h6000_0002, 32'h6000_0003, 3, 1'b1);
    drain("drain_post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
